// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: saturating coin credit, per-item stock,
// one-cycle vend, then greedy one-coin-per-cycle change/refund.
//
// Handshake: every input is a single-cycle strobe with no back-pressure. The
// controller samples strobes on each rising edge and answers with registered
// one-cycle pulses in the following cycle. While busy is high, coins are
// rejected and selections/cancels are dropped silently.
module vending_machine_multi #(
    parameter int  N_ITEMS    = 4,
    parameter int  CREDIT_W   = 8,
    parameter int  MAX_CREDIT = 200,
    parameter int  STOCK_W    = 4,
    localparam int SEL_W      = $clog2(N_ITEMS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          nickle,
    input  logic                          dime,
    input  logic                          quarter,
    input  logic                          sel_valid,
    input  logic [SEL_W-1:0]              sel_item,
    input  logic                          cancel,
    input  logic [N_ITEMS*CREDIT_W-1:0]   price_table,
    input  logic                          restock_valid,
    input  logic [SEL_W-1:0]              restock_item,
    input  logic [STOCK_W-1:0]            restock_cnt,
    output logic                          vend,
    output logic [SEL_W-1:0]              vend_item,
    output logic                          chg_nickle,
    output logic                          chg_dime,
    output logic                          chg_quarter,
    output logic                          coin_reject,
    output logic                          sold_out,
    output logic                          insufficient,
    output logic                          busy,
    output logic [CREDIT_W-1:0]           credit
);

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } state_t;

    localparam logic [CREDIT_W:0]   CREDIT_CAP = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] V_NICKLE   = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] V_DIME     = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] V_QUARTER  = CREDIT_W'(25);

    state_t               state;
    logic [SEL_W-1:0]     vend_sel;
    logic [STOCK_W-1:0]   stock     [N_ITEMS];
    logic [STOCK_W-1:0]   stock_nxt [N_ITEMS];
    logic [STOCK_W:0]     stock_sum [N_ITEMS];

    logic [1:0]           coin_cnt;
    logic                 coin_any;
    logic                 coin_multi;
    logic [CREDIT_W-1:0]  coin_val;
    logic [CREDIT_W:0]    credit_sum;
    logic                 sel_legal;
    logic [STOCK_W-1:0]   sel_stock;
    logic [CREDIT_W-1:0]  sel_price;
    logic [CREDIT_W-1:0]  vend_price;
    logic [CREDIT_W-1:0]  chg_step;
    logic [CREDIT_W-1:0]  credit_left;
    logic [CREDIT_W-1:0]  vend_left;

    // Coin decode and the overflow-safe credit sum (one extra bit).
    always_comb begin
        coin_cnt   = 2'(nickle) + 2'(dime) + 2'(quarter);
        coin_any   = nickle | dime | quarter;
        coin_multi = (coin_cnt > 2'd1);
        coin_val   = quarter ? V_QUARTER : (dime ? V_DIME : (nickle ? V_NICKLE : '0));
        credit_sum = {1'b0, credit} + {1'b0, coin_val};
    end

    // Selection lookup, greedy change step and post-vend remainder.
    always_comb begin
        sel_legal   = (int'(sel_item) < N_ITEMS);
        sel_stock   = sel_legal ? stock[sel_item] : '0;
        sel_price   = price_table[int'(sel_item)*CREDIT_W +: CREDIT_W];
        vend_price  = price_table[int'(vend_sel)*CREDIT_W +: CREDIT_W];
        chg_step    = (credit >= V_QUARTER) ? V_QUARTER :
                      ((credit >= V_DIME) ? V_DIME : V_NICKLE);
        credit_left = credit - chg_step;
        vend_left   = credit - vend_price;
    end

    // Next stock: saturating restock first, then the vend decrement.
    always_comb begin
        for (int i = 0; i < N_ITEMS; i++) begin
            stock_sum[i] = {1'b0, stock[i]} +
                ((restock_valid && int'(restock_item) == i) ? {1'b0, restock_cnt} : '0);
            stock_nxt[i] = stock_sum[i][STOCK_W] ? '1 : stock_sum[i][STOCK_W-1:0];
            if (state == ST_VEND && int'(vend_sel) == i)
                stock_nxt[i] = stock_nxt[i] - STOCK_W'(1);
        end
    end

    // Per-item stock counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ITEMS; i++) stock[i] <= '0;
        end else begin
            for (int i = 0; i < N_ITEMS; i++) stock[i] <= stock_nxt[i];
        end
    end

    // Controller FSM with registered credit, busy and one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_ACCEPT;
            vend_sel     <= '0;
            credit       <= '0;
            busy         <= 1'b0;
            vend         <= 1'b0;
            vend_item    <= '0;
            chg_nickle   <= 1'b0;
            chg_dime     <= 1'b0;
            chg_quarter  <= 1'b0;
            coin_reject  <= 1'b0;
            sold_out     <= 1'b0;
            insufficient <= 1'b0;
        end else begin
            vend         <= 1'b0;
            vend_item    <= '0;
            chg_nickle   <= 1'b0;
            chg_dime     <= 1'b0;
            chg_quarter  <= 1'b0;
            coin_reject  <= 1'b0;
            sold_out     <= 1'b0;
            insufficient <= 1'b0;
            case (state)
                ST_ACCEPT: begin
                    if (cancel) begin
                        coin_reject <= coin_any;
                        if (credit != '0) begin
                            state <= ST_CHANGE;
                            busy  <= 1'b1;
                        end
                    end else if (sel_valid) begin
                        coin_reject <= coin_any;
                        if (!sel_legal || sel_stock == '0) begin
                            sold_out <= 1'b1;
                        end else if (credit < sel_price) begin
                            insufficient <= 1'b1;
                        end else begin
                            state     <= ST_VEND;
                            busy      <= 1'b1;
                            vend      <= 1'b1;
                            vend_item <= sel_item;
                            vend_sel  <= sel_item;
                        end
                    end else if (coin_any) begin
                        if (coin_multi || credit_sum > CREDIT_CAP)
                            coin_reject <= 1'b1;
                        else
                            credit <= credit_sum[CREDIT_W-1:0];
                    end
                end
                ST_VEND: begin
                    coin_reject <= coin_any;
                    credit      <= vend_left;
                    busy        <= (vend_left != '0);
                    state       <= (vend_left != '0) ? ST_CHANGE : ST_ACCEPT;
                end
                ST_CHANGE: begin
                    coin_reject <= coin_any;
                    credit      <= credit_left;
                    chg_quarter <= (chg_step == V_QUARTER);
                    chg_dime    <= (chg_step == V_DIME);
                    chg_nickle  <= (chg_step == V_NICKLE);
                    busy        <= (credit_left != '0);
                    if (credit_left == '0) state <= ST_ACCEPT;
                end
                default: begin
                    state <= ST_ACCEPT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: directed scenarios plus a randomized
// operation stream scored against a transaction-level model.
module tb_vending_machine_multi;

    localparam int N_ITEMS = 4;
    localparam int CREDIT_W = 8;
    localparam int MAX_CREDIT = 200;
    localparam int STOCK_W = 4;
    localparam int SEL_W = 2;
    localparam logic [2:0] CN = 3'b001;
    localparam logic [2:0] CD = 3'b010;
    localparam logic [2:0] CQ = 3'b100;

    logic clk, rst_n, nickle, dime, quarter, sel_valid, cancel, restock_valid;
    logic [SEL_W-1:0] sel_item, restock_item, vend_item;
    logic [N_ITEMS*CREDIT_W-1:0] price_table;
    logic [STOCK_W-1:0] restock_cnt;
    logic vend, chg_nickle, chg_dime, chg_quarter, coin_reject, sold_out, insufficient, busy;
    logic [CREDIT_W-1:0] credit;

    int errors = 0;
    int checks = 0;
    int op_idx = 0;
    int m_credit;
    int m_stock [N_ITEMS];
    int m_price [N_ITEMS] = '{5, 15, 35, 25};
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    vending_machine_multi #(
        .N_ITEMS(N_ITEMS), .CREDIT_W(CREDIT_W), .MAX_CREDIT(MAX_CREDIT), .STOCK_W(STOCK_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .nickle(nickle), .dime(dime), .quarter(quarter),
        .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
        .price_table(price_table), .restock_valid(restock_valid),
        .restock_item(restock_item), .restock_cnt(restock_cnt), .vend(vend),
        .vend_item(vend_item), .chg_nickle(chg_nickle), .chg_dime(chg_dime),
        .chg_quarter(chg_quarter), .coin_reject(coin_reject), .sold_out(sold_out),
        .insufficient(insufficient), .busy(busy), .credit(credit)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Event tags: 1 vend, 2 quarter, 3 dime, 4 nickel, 5 sold_out, 6 insufficient, 7 reject
    function automatic logic [31:0] ev(int cyc, int tag, int data);
        return 32'(op_idx * 4096 + cyc * 256 + tag * 16 + data);
    endfunction

    // Model: refund the whole model credit as quarters, dimes, nickels
    task automatic push_change(input int start);
        int c, nq, nd, nn, rem;
        c = start;
        nq = m_credit / 25;
        rem = m_credit % 25;
        nd = rem / 10;
        nn = (rem % 10) / 5;
        repeat (nq) begin exp_q.push_back(ev(c, 2, 0)); c++; end
        repeat (nd) begin exp_q.push_back(ev(c, 3, 0)); c++; end
        repeat (nn) begin exp_q.push_back(ev(c, 4, 0)); c++; end
    endtask

    // Model: expected outcome of one operation (inputs of cycle 0 and cycle 1)
    task automatic model_op(input logic [2:0] c0, input bit can, input bit sel, input int item,
                            input logic [2:0] c1, input bit rv, input int ri, input int rc);
        int n, v, s;
        bit vended;
        n = $countones(c0);
        v = c0[2] ? 25 : (c0[1] ? 10 : 5);
        vended = 0;
        if (can) begin
            if (n > 0) exp_q.push_back(ev(1, 7, 0));
            if (m_credit > 0) begin push_change(2); m_credit = 0; end
        end else if (sel) begin
            if (m_stock[item] == 0) exp_q.push_back(ev(1, 5, 0));
            else if (m_credit < m_price[item]) exp_q.push_back(ev(1, 6, 0));
            else begin
                exp_q.push_back(ev(1, 1, item));
                m_credit -= m_price[item];
                vended = 1;
            end
            if (n > 0) exp_q.push_back(ev(1, 7, 0));
            if (vended && m_credit > 0) begin push_change(3); m_credit = 0; end
        end else if (n > 1) begin
            exp_q.push_back(ev(1, 7, 0));
        end else if (n == 1) begin
            if (m_credit + v <= MAX_CREDIT) m_credit += v;
            else exp_q.push_back(ev(1, 7, 0));
        end
        if (c1 != 3'b000) exp_q.push_back(ev(2, 7, 0));
        if (rv) begin
            s = m_stock[ri] + rc;
            m_stock[ri] = (s > 15) ? 15 : s;
        end
        if (vended) m_stock[item] -= 1;
    endtask

    // Monitor: log every pulse seen in the current cycle
    task automatic record(input int cyc);
        if (vend === 1'b1) obs_q.push_back(ev(cyc, 1, int'(vend_item)));
        if (vend !== 1'b1 && vend_item !== '0) obs_q.push_back(ev(cyc, 8, int'(vend_item)));
        if (chg_quarter === 1'b1) obs_q.push_back(ev(cyc, 2, 0));
        if (chg_dime === 1'b1) obs_q.push_back(ev(cyc, 3, 0));
        if (chg_nickle === 1'b1) obs_q.push_back(ev(cyc, 4, 0));
        if (sold_out === 1'b1) obs_q.push_back(ev(cyc, 5, 0));
        if (insufficient === 1'b1) obs_q.push_back(ev(cyc, 6, 0));
        if (coin_reject === 1'b1) obs_q.push_back(ev(cyc, 7, 0));
    endtask

    // Driver: apply one operation, then follow the DUT until it is idle
    task automatic run_op(input logic [2:0] c0, input bit can, input bit sel, input int item,
                          input logic [2:0] c1, input bit rv, input int ri, input int rc);
        int cyc;
        {quarter, dime, nickle} = c0;
        cancel = can;
        sel_valid = sel;
        sel_item = SEL_W'(item);
        @(negedge clk);
        {quarter, dime, nickle} = c1;
        cancel = 1'b0;
        sel_valid = 1'b0;
        sel_item = '0;
        restock_valid = rv;
        restock_item = SEL_W'(ri);
        restock_cnt = STOCK_W'(rc);
        record(1);
        @(negedge clk);
        {quarter, dime, nickle} = 3'b000;
        restock_valid = 1'b0;
        restock_item = '0;
        restock_cnt = '0;
        cyc = 2;
        record(cyc);
        while (busy === 1'b1 && cyc < 14) begin
            @(negedge clk);
            cyc++;
            record(cyc);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL op%0d_idle: busy=%b after %0d cycles, required 0", op_idx, busy, cyc);
        end
        op_idx++;
    endtask

    task automatic op(input logic [2:0] c0, input bit can, input bit sel, input int item,
                      input logic [2:0] c1, input bit rv, input int ri, input int rc);
        model_op(c0, can, sel, item, c1, rv, ri, rc);
        run_op(c0, can, sel, item, c1, rv, ri, rc);
    endtask

    task automatic coin(input logic [2:0] c);   op(c, 0, 0, 0, 3'b000, 0, 0, 0); endtask
    task automatic select(input int item);      op(3'b000, 0, 1, item, 3'b000, 0, 0, 0); endtask
    task automatic refund();                    op(3'b000, 1, 0, 0, 3'b000, 0, 0, 0); endtask
    task automatic restock(input int i, input int n); op(3'b000, 0, 0, 0, 3'b000, 1, i, n); endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {nickle, dime, quarter, sel_valid, cancel, restock_valid} = '0;
        sel_item = '0; restock_item = '0; restock_cnt = '0;
        price_table = {8'd25, 8'd35, 8'd15, 8'd5};
        m_credit = 0;
        for (int i = 0; i < N_ITEMS; i++) m_stock[i] = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (credit !== 8'd0) begin errors++; $display("FAIL reset_credit: got %0d required 0", credit); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++;
        if ({vend, vend_item, chg_nickle, chg_dime, chg_quarter, coin_reject, sold_out, insufficient} !== '0) begin
            errors++;
            $display("FAIL reset_pulses: got %b required all 0",
                     {vend, vend_item, chg_nickle, chg_dime, chg_quarter, coin_reject, sold_out, insufficient});
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N_ITEMS; i++) select(i);
        exp_q.sort(); obs_q.sort();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL reset_events: got %0d events required %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[k]) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL reset_event%0d: got %h required %h", k, obs_q[k], exp_q[k]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_exact_vend();
        restock(2, 3);
        coin(CQ);
        coin(CD);
        select(2);
        checks++;
        if (credit !== 8'd0) begin errors++; $display("FAIL exact_credit: got %0d required 0", credit); end
        exp_q.sort(); obs_q.sort();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL exact_events: got %0d events required %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[k]) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL exact_event%0d: got %h required %h", k, obs_q[k], exp_q[k]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_change_sold_out();
        restock(1, 1);
        coin(CQ);
        coin(CQ);
        select(1);
        checks++;
        if (credit !== 8'd0) begin errors++; $display("FAIL change_credit: got %0d required 0", credit); end
        select(1);
        exp_q.sort(); obs_q.sort();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL change_events: got %0d events required %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[k]) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL change_event%0d: got %h required %h", k, obs_q[k], exp_q[k]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_cancel();
        coin(CD);
        coin(CN);
        coin(CN);
        checks++;
        if (credit !== 8'd20) begin errors++; $display("FAIL cancel_credit_before: got %0d required 20", credit); end
        op(3'b000, 1, 0, 0, CN, 0, 0, 0);
        checks++;
        if (credit !== 8'd0) begin errors++; $display("FAIL cancel_credit_after: got %0d required 0", credit); end
        exp_q.sort(); obs_q.sort();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL cancel_events: got %0d events required %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[k]) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL cancel_event%0d: got %h required %h", k, obs_q[k], exp_q[k]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_saturation();
        repeat (7) coin(CQ);
        coin(CD);
        coin(CN);
        checks++;
        if (credit !== 8'd190) begin errors++; $display("FAIL sat_credit_190: got %0d required 190", credit); end
        coin(CQ);
        checks++;
        if (credit !== 8'd190) begin errors++; $display("FAIL sat_credit_reject: got %0d required 190", credit); end
        coin(CD);
        checks++;
        if (credit !== 8'd200) begin errors++; $display("FAIL sat_credit_200: got %0d required 200", credit); end
        refund();
        exp_q.sort(); obs_q.sort();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL sat_events: got %0d events required %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[k]) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL sat_event%0d: got %h required %h", k, obs_q[k], exp_q[k]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reject_insufficient();
        coin(CN | CD);
        checks++;
        if (credit !== 8'd0) begin errors++; $display("FAIL multi_coin_credit: got %0d required 0", credit); end
        coin(CD);
        select(2);
        checks++;
        if (credit !== 8'd10) begin errors++; $display("FAIL insuff_credit: got %0d required 10", credit); end
        op(CQ, 0, 1, 2, 3'b000, 0, 0, 0);
        refund();
        exp_q.sort(); obs_q.sort();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL insuff_events: got %0d events required %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[k]) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL insuff_event%0d: got %h required %h", k, obs_q[k], exp_q[k]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_restock_vend();
        restock(3, 15);
        coin(CQ);
        op(3'b000, 0, 1, 3, 3'b000, 1, 3, 5);
        repeat (15) begin
            coin(CQ);
            select(3);
        end
        refund();
        exp_q.sort(); obs_q.sort();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL restock_events: got %0d events required %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[k]) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL restock_event%0d: got %h required %h", k, obs_q[k], exp_q[k]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_change();
        repeat (8) coin(CQ);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        m_credit = 0;
        for (int i = 0; i < N_ITEMS; i++) m_stock[i] = 0;
        #1;
        checks++;
        if (credit !== 8'd0) begin errors++; $display("FAIL midreset_credit: got %0d required 0", credit); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b required 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        coin(CN);
        checks++;
        if (credit !== 8'd5) begin errors++; $display("FAIL midreset_accept: got %0d required 5", credit); end
        select(1);
        refund();
        exp_q.sort(); obs_q.sort();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL midreset_events: got %0d events required %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[k]) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL midreset_event%0d: got %h required %h", k, obs_q[k], exp_q[k]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [2:0] cv;
        int r;
        for (int t = 0; t < 250; t++) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 2))
                0: cv = CN;
                1: cv = CD;
                default: cv = CQ;
            endcase
            if (r < 45) coin(cv);
            else if (r < 50) coin(cv | (($urandom_range(0, 1) == 1) ? CN : CD) | CQ);
            else if (r < 68) select($urandom_range(0, 3));
            else if (r < 74) op(cv, 0, 1, $urandom_range(0, 3), 3'b000, 0, 0, 0);
            else if (r < 84) op(($urandom_range(0, 3) == 0) ? cv : 3'b000, 1, 0, 0, 3'b000, 0, 0, 0);
            else restock($urandom_range(0, 3), $urandom_range(0, 15));
            checks++;
            if (int'(credit) !== m_credit) begin
                errors++;
                $display("FAIL rand_credit op%0d: got %0d required %0d", t, credit, m_credit);
            end
        end
        exp_q.sort(); obs_q.sort();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_events: got %0d events required %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[k]) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand_event%0d: got %h required %h", k, obs_q[k], exp_q[k]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_exact_vend();
        test_change_sold_out();
        test_cancel();
        test_saturation();
        test_reject_insufficient();
        test_restock_vend();
        test_reset_mid_change();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
